dac_arbiter: RTL and testbench
==============================

Name: dac_arbiter

Overview:
- Shares one DAC SPI channel between MASTERS independent requesters, e.g. autoapproach, the PI loop and the raster scanner.
- Every requester uses the standard arm/finished handshake and sees the arbiter as a private DAC.
- Arbitration is round-robin, gated by a per-master enable mask that software controls.
- Sits between the requesters and the DAC SPI master; the DAC word is latched, so the DAC sees a stable value for the whole transfer.

Parameters:
MASTERS, 3, number of requesters (2..8).
MASTER_WID, 2, width of the grant index; must satisfy 2^MASTER_WID >= MASTERS.
DAC_WID, 24, width of the DAC command word.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
master_arm  input  MASTERS  per-master request; held high until that master sees finished.
master_dac_out  input  MASTERS*DAC_WID  per-master DAC word; master i occupies bits [i*DAC_WID +: DAC_WID].
master_enable  input  MASTERS  per-master enable mask; a disabled master is never granted.
master_finished  output  MASTERS  per-master completion flag.
grant  output  MASTERS  one-hot owner of the DAC; all zero when idle.
busy  output  1  high whenever state != IDLE.
dac_arm  output  1  to the DAC SPI master.
dac_out  output  DAC_WID  latched word to the DAC SPI master.
dac_finished  input  1  from the DAC SPI master; stays high until dac_arm drops.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; grant, master_finished, dac_arm, busy all 0; dac_out=0.
  - last pointer = MASTERS-1, so master 0 wins first.
  - Reset mid-transfer drops dac_arm the same edge; no master_finished pulse is produced.
- Request vector: req = master_arm & master_enable.
- IDLE:
  - If req != 0, pick the first set bit searching from index last+1 upward, wrapping modulo MASTERS.
  - Next edge: grant = onehot(sel); dac_out = that master's word; dac_arm = 1; state -> ARMED.
  - Latency from master_arm rising to dac_arm rising is 1 cycle.
  - If req == 0, stay in IDLE.
- ARMED:
  - Wait for dac_finished.
  - If the granted master_arm is still high: master_finished[sel] = 1, state -> DONE.
  - If the granted master_arm has dropped (abort): dac_arm = 0, state -> RELEASE, no finished pulse. An in-flight SPI transfer always completes; the arbiter never drops dac_arm before dac_finished.
- DONE:
  - Hold dac_arm=1 and master_finished[sel]=1 until master_arm[sel] is low.
  - Then: dac_arm=0, master_finished=0, state -> RELEASE.
- RELEASE:
  - Wait until dac_finished==0.
  - Then: grant=0, last=sel, state -> IDLE.
  - A new grant is possible on the following edge, so the minimum gap between transfers is 1 idle cycle.
- dac_out is held constant from grant until return to IDLE, even if master_dac_out changes.
- Enable and request changes:
  - master_enable changes affect only future arbitration; deasserting enable for the current owner does not abort its transfer.
  - Non-granted master_arm lines are ignored while busy; those masters simply keep waiting.
  - Simultaneous requests are resolved only by the round-robin order; there is no fixed priority beyond the reset value of last.
- Invariants:
  - grant is one-hot or zero.
  - master_finished is a subset of grant.
  - At most one master_finished bit is high at any time.

Test Plan:
- Single master: master 1 arms with word 24'h1ABCDE -> 1 cycle later grant=3'b010, dac_arm=1, dac_out=24'h1ABCDE; DAC model asserts finished after 10 cycles -> master_finished[1]=1; master drops arm -> dac_arm=0, grant=0 after dac_finished falls.
- Simultaneous after reset: masters 0 and 2 arm on the same cycle -> master 0 served first, then master 2; words reach the DAC in that order.
- Fairness: all three masters rearm immediately after each finished, for 9 transfers -> grant sequence 0,1,2,0,1,2,0,1,2; no master served twice in a row.
- Enable mask: master_enable=3'b101 and all masters arm -> master 1 never granted; set enable[1]=1 -> master 1 served within the next 3 transfers.
- Abort: master 0 drops arm 2 cycles after grant -> dac_arm stays high until dac_finished, master_finished never pulses, then grant passes to the next requester.
- Reset mid-transfer: rst=1 while in DONE -> next edge dac_arm=0, grant=0, master_finished=0, busy=0; the first request after reset is granted with master 0 priority.

Source files
------------

// File: rtl/dac_arbiter_if.sv
// Requester-side and DAC-side signals of the shared DAC channel.
// The arbiter takes the slave view; the requesters and the DAC SPI master drive the other side.
interface dac_arbiter_if #(
  parameter int MASTERS = 3,
  parameter int DAC_WID = 24
);
  logic [MASTERS-1:0]         master_arm;
  logic [MASTERS*DAC_WID-1:0] master_dac_out;
  logic [MASTERS-1:0]         master_enable;
  logic [MASTERS-1:0]         master_finished;
  logic [MASTERS-1:0]         grant;
  logic                       busy;
  logic                       dac_arm;
  logic [DAC_WID-1:0]         dac_out;
  logic                       dac_finished;

  modport slave (
    input  master_arm, master_dac_out, master_enable, dac_finished,
    output master_finished, grant, busy, dac_arm, dac_out
  );

  modport master (
    output master_arm, master_dac_out, master_enable, dac_finished,
    input  master_finished, grant, busy, dac_arm, dac_out
  );
endinterface

// File: rtl/dac_arbiter.sv
// Round-robin arbiter sharing one DAC SPI channel between several arm/finished requesters.
// The owner's word is latched at grant so the DAC sees a stable value for the whole transfer.
module dac_arbiter #(
  parameter int MASTERS    = 3,
  parameter int MASTER_WID = 2,
  parameter int DAC_WID    = 24
) (
  input  logic         clk,
  input  logic         rst,
  dac_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE, RELEASE} state_t;

  state_t                state_q;
  logic [MASTERS-1:0]    grant_q;
  logic [MASTERS-1:0]    finished_q;
  logic                  dac_arm_q;
  logic [DAC_WID-1:0]    dac_out_q;
  logic [MASTER_WID-1:0] last_q;
  logic [MASTER_WID-1:0] sel_q;

  logic [MASTERS-1:0]    req;
  logic [MASTERS-1:0]    onehot_d;
  logic [MASTER_WID-1:0] sel_d;
  logic                  found_d;
  logic [DAC_WID-1:0]    word_d;
  logic                  owner_arm;
  int                    cand;

  assign req = bus.master_arm & bus.master_enable;

  // grant_q is the one-hot of the owner, so it selects the owner's arm line directly
  assign owner_arm = |(bus.master_arm & grant_q);

  // first active request after the previous owner, wrapping modulo MASTERS
  always_comb begin
    sel_d   = '0;
    found_d = 1'b0;
    cand    = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand = int'(last_q) + k;
      if (cand >= MASTERS) cand = cand - MASTERS;
      if (!found_d && 1'(req >> cand)) begin
        sel_d   = MASTER_WID'(cand);
        found_d = 1'b1;
      end
    end
  end

  assign onehot_d = {{(MASTERS-1){1'b0}}, 1'b1} << sel_d;
  assign word_d   = DAC_WID'(bus.master_dac_out >> (int'(sel_d) * DAC_WID));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      finished_q <= '0;
      dac_arm_q  <= 1'b0;
      dac_out_q  <= '0;
      last_q     <= MASTER_WID'(MASTERS - 1);
      sel_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found_d) begin
            sel_q     <= sel_d;
            grant_q   <= onehot_d;
            dac_out_q <= word_d;
            dac_arm_q <= 1'b1;
            state_q   <= ARMED;
          end
        end
        // an aborted request still lets the in-flight SPI transfer complete
        ARMED: begin
          if (bus.dac_finished) begin
            if (owner_arm) begin
              finished_q <= grant_q;
              state_q    <= DONE;
            end else begin
              dac_arm_q <= 1'b0;
              state_q   <= RELEASE;
            end
          end
        end
        DONE: begin
          if (!owner_arm) begin
            dac_arm_q  <= 1'b0;
            finished_q <= '0;
            state_q    <= RELEASE;
          end
        end
        RELEASE: begin
          if (!bus.dac_finished) begin
            grant_q <= '0;
            last_q  <= sel_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant           = grant_q;
  assign bus.master_finished = finished_q;
  assign bus.dac_arm         = dac_arm_q;
  assign bus.dac_out         = dac_out_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dac_arbiter.sv
// Bench for dac_arbiter: requester and DAC behaviour models, a transaction-level reference
// of the arbitration rules compared every cycle, and directed scenarios with literal expectations.
module tb_dac_arbiter;

  localparam int M = 3;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dac_arbiter_if #(.MASTERS(M), .DAC_WID(W)) bus ();

  dac_arbiter #(.MASTERS(M), .MASTER_WID(2), .DAC_WID(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic autoMode[M];
  int   pending[M];
  int   raiseCount[M];
  int   dacCnt;
  int   fin0Cycles;
  int   grantLog[$];
  logic [W-1:0] wordLog[$];
  logic [M-1:0] prevGrant;

  // reference model: owner index (-1 = none), service order list, expected outputs
  int   owner = -1;
  int   order[M];
  logic mArm  = 1'b0;
  logic mFin  = 1'b0;
  logic [W-1:0] mWord = '0;
  logic modelValid = 1'b0;

  function automatic logic bitOf(logic [M-1:0] v, int i);
    logic [M-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic logic [M-1:0] oneHot(int i);
    return {{(M-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [W-1:0] wordOf(int i);
    logic [M*W-1:0] t;
    t = bus.master_dac_out >> (i * W);
    return t[W-1:0];
  endfunction

  function automatic int idxOf(logic [M-1:0] g);
    for (int k = 0; k < M; k++) if (bitOf(g, k)) return k;
    return -1;
  endfunction

  // model updates from the rules: rotate the service order past each released owner
  always @(posedge clk) begin : refModel
    int nOwner;
    logic nArm, nFin;
    logic [W-1:0] nWord;
    int nOrder[M];
    logic [M-1:0] req;
    nOwner = owner; nArm = mArm; nFin = mFin; nWord = mWord; nOrder = order;
    req = bus.master_arm & bus.master_enable;
    if (rst) begin
      nOwner = -1; nArm = 1'b0; nFin = 1'b0; nWord = '0;
      for (int k = 0; k < M; k++) nOrder[k] = k;
    end else if (owner < 0) begin
      for (int k = 0; k < M; k++) begin
        if (nOwner < 0 && bitOf(req, order[k])) begin
          nOwner = order[k]; nArm = 1'b1; nWord = wordOf(order[k]);
        end
      end
    end else if (mArm && !mFin) begin
      if (bus.dac_finished) begin
        if (bitOf(bus.master_arm, owner)) nFin = 1'b1;
        else nArm = 1'b0;
      end
    end else if (mFin) begin
      if (!bitOf(bus.master_arm, owner)) begin
        nFin = 1'b0; nArm = 1'b0;
      end
    end else if (!bus.dac_finished) begin
      for (int k = 0; k < M; k++) nOrder[k] = (owner + 1 + k) % M;
      nOwner = -1;
    end
    owner      <= nOwner;
    mArm       <= nArm;
    mFin       <= nFin;
    mWord      <= nWord;
    order      <= nOrder;
    modelValid <= 1'b1;
  end

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareCycle();
    logic [M-1:0] expGrant, expFin;
    if (!modelValid) return;
    expGrant = (owner >= 0) ? oneHot(owner) : '0;
    expFin   = mFin ? expGrant : '0;
    checkOutput("cycle",
      64'({bus.grant, bus.master_finished, bus.dac_arm, bus.busy, bus.dac_out}),
      64'({expGrant, expFin, mArm, (owner >= 0), mWord}));
    if (bus.grant != '0 && prevGrant == '0) begin
      grantLog.push_back(idxOf(bus.grant));
      wordLog.push_back(bus.dac_out);
    end
    prevGrant = bus.grant;
    if (bitOf(bus.master_finished, 0)) fin0Cycles++;
  endtask

  task automatic setArm(int i, logic v);
    if (v) bus.master_arm = bus.master_arm | oneHot(i);
    else   bus.master_arm = bus.master_arm & ~oneHot(i);
  endtask

  task automatic setWord(int i, logic [W-1:0] w);
    logic [M*W-1:0] mask, val;
    mask = {{(M*W-W){1'b0}}, {W{1'b1}}} << (i * W);
    val  = {{(M*W-W){1'b0}}, w} << (i * W);
    bus.master_dac_out = (bus.master_dac_out & ~mask) | val;
  endtask

  // one cycle: compare at negedge, then drive DAC and requester models just after posedge
  task automatic applyStimulus(int n);
    repeat (n) begin
      @(negedge clk);
      compareCycle();
      @(posedge clk);
      #1;
      if (rst) begin
        bus.dac_finished = 1'b0; dacCnt = 0;
      end else if (bus.dac_arm && !bus.dac_finished) begin
        if (dacCnt == 9) bus.dac_finished = 1'b1;
        else dacCnt++;
      end else if (!bus.dac_arm) begin
        bus.dac_finished = 1'b0; dacCnt = 0;
      end
      for (int i = 0; i < M; i++) begin
        if (autoMode[i]) begin
          if (bitOf(bus.master_arm, i) && bitOf(bus.master_finished, i)) begin
            setArm(i, 1'b0);
          end else if (!bitOf(bus.master_arm, i) && pending[i] > 0) begin
            pending[i]--;
            raiseCount[i]++;
            setWord(i, {8'(i + 1), 16'(raiseCount[i])});
            setArm(i, 1'b1);
          end
        end
      end
    end
  endtask

  function automatic logic pendingAny();
    for (int i = 0; i < M; i++) if (pending[i] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic waitIdle(string name);
    int n = 0;
    while ((bus.busy || bus.master_arm != '0 || pendingAny()) && n < 3000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput({name, " idle in budget"}, 64'(n < 3000), 64'(1));
  endtask

  task automatic waitGrant(string name, int i);
    int n = 0;
    while (!bitOf(bus.grant, i) && n < 200) begin applyStimulus(1); n++; end
    checkOutput(name, 64'(bitOf(bus.grant, i)), 64'(1));
  endtask

  task automatic waitFinished(string name, int i);
    int n = 0;
    while (!bitOf(bus.master_finished, i) && n < 200) begin applyStimulus(1); n++; end
    checkOutput(name, 64'(bitOf(bus.master_finished, i)), 64'(1));
  endtask

  task automatic checkLog(string name, int exp[$]);
    checkOutput({name, " count"}, 64'(grantLog.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      checkOutput($sformatf("%s grant #%0d", name, k),
                  64'(k < grantLog.size() ? grantLog[k] : -1), 64'(exp[k]));
    end
  endtask

  initial begin
    int n;
    int fin0Before;
    for (int i = 0; i < M; i++) begin
      autoMode[i] = 1'b0; pending[i] = 0; raiseCount[i] = 0;
    end
    dacCnt = 0; fin0Cycles = 0; prevGrant = '0;
    bus.master_arm     = '0;
    bus.master_enable  = 3'b111;
    bus.master_dac_out = '0;
    bus.dac_finished   = 1'b0;

    // reset values
    applyStimulus(3);
    checkOutput("reset grant", 64'(bus.grant), 64'(0));
    checkOutput("reset dac_arm", 64'(bus.dac_arm), 64'(0));
    checkOutput("reset busy", 64'(bus.busy), 64'(0));
    checkOutput("reset finished", 64'(bus.master_finished), 64'(0));
    checkOutput("reset dac_out", 64'(bus.dac_out), 64'(0));
    rst = 1'b0;
    applyStimulus(2);

    // single master, one-cycle grant latency, word held while the source changes
    setWord(1, 24'h1ABCDE);
    setArm(1, 1'b1);
    applyStimulus(1);
    checkOutput("t1 grant", 64'(bus.grant), 64'(3'b010));
    checkOutput("t1 dac_arm", 64'(bus.dac_arm), 64'(1));
    checkOutput("t1 dac_out", 64'(bus.dac_out), 64'(24'h1ABCDE));
    setWord(1, 24'h555555);
    autoMode[1] = 1'b1;
    waitFinished("t1 finished", 1);
    checkOutput("t1 dac_out held", 64'(bus.dac_out), 64'(24'h1ABCDE));
    waitIdle("t1");
    checkOutput("t1 grant released", 64'(bus.grant), 64'(0));
    checkOutput("t1 dac_arm released", 64'(bus.dac_arm), 64'(0));

    // simultaneous requests right after reset: master 0 first
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    grantLog.delete(); wordLog.delete();
    setWord(0, 24'hA00000);
    setWord(2, 24'hC00002);
    autoMode[0] = 1'b1; autoMode[2] = 1'b1;
    setArm(0, 1'b1); setArm(2, 1'b1);
    waitIdle("t2");
    checkLog("t2", '{0, 2});
    checkOutput("t2 word 0", 64'(wordLog.size() > 0 ? wordLog[0] : '0), 64'(24'hA00000));
    checkOutput("t2 word 1", 64'(wordLog.size() > 1 ? wordLog[1] : '0), 64'(24'hC00002));

    // fairness: everyone rearms immediately, previous owner was master 2
    grantLog.delete();
    for (int i = 0; i < M; i++) begin autoMode[i] = 1'b1; pending[i] = 3; end
    waitIdle("t3");
    checkLog("t3", '{0, 1, 2, 0, 1, 2, 0, 1, 2});

    // enable mask: master 1 locked out until re-enabled after three grants
    grantLog.delete();
    bus.master_enable = 3'b101;
    for (int i = 0; i < M; i++) pending[i] = 2;
    n = 0;
    while (grantLog.size() < 3 && n < 3000) begin applyStimulus(1); n++; end
    bus.master_enable = 3'b111;
    waitIdle("t4");
    checkLog("t4", '{0, 2, 0, 1, 2, 1});

    // abort: master 0 drops arm two cycles after grant, master 1 waiting
    grantLog.delete();
    autoMode[0] = 1'b0;
    fin0Before = fin0Cycles;
    setWord(0, 24'h0000AA); setWord(1, 24'h0000BB);
    setArm(0, 1'b1); setArm(1, 1'b1);
    waitGrant("t5 grant 0", 0);
    applyStimulus(2);
    setArm(0, 1'b0);
    applyStimulus(1);
    checkOutput("t5 dac_arm held", 64'(bus.dac_arm), 64'(1));
    waitIdle("t5");
    checkOutput("t5 no finished for 0", 64'(fin0Cycles - fin0Before), 64'(0));
    checkLog("t5", '{0, 1});

    // reset while the owner sits in DONE
    autoMode[2] = 1'b0;
    setWord(2, 24'h222222);
    setArm(2, 1'b1);
    waitFinished("t6 finished", 2);
    checkOutput("t6 finished vec", 64'(bus.master_finished), 64'(3'b100));
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("t6 dac_arm", 64'(bus.dac_arm), 64'(0));
    checkOutput("t6 grant", 64'(bus.grant), 64'(0));
    checkOutput("t6 finished", 64'(bus.master_finished), 64'(0));
    checkOutput("t6 busy", 64'(bus.busy), 64'(0));
    setArm(2, 1'b0);
    rst = 1'b0;
    applyStimulus(1);
    grantLog.delete();
    for (int i = 0; i < M; i++) begin autoMode[i] = 1'b1; pending[i] = 1; end
    waitIdle("t6");
    checkLog("t6", '{0, 1, 2});

    applyStimulus(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
